// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Contents: sequencer state encoding, next-PC select codes, address width,
// instruction size and a misaligned-target helper.
package pc_fetch_sequencer_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FAULT  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // Which value the PC register loads at the next edge.
    typedef enum logic [1:0] {
        SEL_HOLD     = 2'd0,
        SEL_SEQ      = 2'd1,
        SEL_REDIRECT = 2'd2
    } pc_sel_t;

    // Redirect targets must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-control bundle between the sequencer and its environment
// (hazard unit, branch resolution, instruction memory, IF/ID register).
//   master: the sequencer (drives imem_req, pc, pc_plus4, if_valid, flush,
//           fault, halted, stall_cycles)
//   slave : the environment (drives stall, redirect, redirect_target, halt,
//           imem_ready)
// CNT_W must match the CNT_W of the sequencer attached to this bundle.
interface pc_fetch_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    import pc_fetch_sequencer_pkg::*;

    logic             stall;
    logic             redirect;
    logic [XLEN-1:0]  redirect_target;
    logic             halt;
    logic             imem_ready;
    logic             imem_req;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             if_valid;
    logic             flush;
    logic             fault;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  stall, redirect, redirect_target, halt, imem_ready,
        output imem_req, pc, pc_plus4, if_valid, flush, fault, halted,
               stall_cycles
    );

    modport slave (
        output stall, redirect, redirect_target, halt, imem_ready,
        input  imem_req, pc, pc_plus4, if_valid, flush, fault, halted,
               stall_cycles
    );

endinterface

// File: rtl/pc_fetch_sequencer_pc_next_select.sv
// Combinational next-PC selection.
// Ports:
//   pc              in  current PC
//   redirect_target in  branch/jump target
//   sel             in  decoded next-PC decision
//   pc_plus4        out pc + 4, wrapping modulo 2^32
//   pc_next         out value the PC register loads next
module pc_next_select
    import pc_fetch_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] redirect_target,
    input  pc_sel_t         sel,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] pc_next
);

    assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_SEQ:      pc_next = pc_plus4;
            SEL_REDIRECT: pc_next = redirect_target;
            default:      pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and IF-stage fetch sequencer.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  master side of pc_fetch_sequencer_if (stall/redirect/halt/imem_ready
//        in; imem_req, pc, pc_plus4, if_valid, flush, fault, halted,
//        stall_cycles out)
// imem_req, if_valid, flush and pc_plus4 are combinational; pc, fault,
// halted and stall_cycles come straight from flops.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master bus
);

    state_t           state_q;
    logic [XLEN-1:0]  pc_q;
    logic             fault_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             run;
    logic             do_halt;
    logic             do_redirect;
    logic             redirect_ok;
    logic             redirect_bad;
    logic             do_stall;
    logic             do_fetch;
    logic             fetch_accept;
    pc_sel_t          pc_sel;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  pc_plus4;

    // Per-cycle decision in RUN: halt > redirect > stall > sequential fetch.
    always_comb begin
        run          = (state_q == ST_RUN);
        do_halt      = run && bus.halt;
        do_redirect  = run && !bus.halt && bus.redirect;
        redirect_ok  = do_redirect && !is_misaligned(bus.redirect_target);
        redirect_bad = do_redirect &&  is_misaligned(bus.redirect_target);
        do_stall     = run && !bus.halt && !bus.redirect && bus.stall;
        do_fetch     = run && !bus.halt && !bus.redirect && !bus.stall;
        fetch_accept = do_fetch && bus.imem_ready;
        pc_sel       = SEL_HOLD;
        if (redirect_ok) begin
            pc_sel = SEL_REDIRECT;
        end else if (fetch_accept) begin
            pc_sel = SEL_SEQ;
        end
    end

    pc_next_select u_next (
        .pc              (pc_q),
        .redirect_target (bus.redirect_target),
        .sel             (pc_sel),
        .pc_plus4        (pc_plus4),
        .pc_next         (pc_next)
    );

    // State, PC, sticky fault, halted flag and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            fault_q     <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            pc_q <= pc_next;
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (do_halt) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (redirect_bad) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                    if (do_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign bus.imem_req     = do_fetch;
    assign bus.if_valid     = fetch_accept;
    assign bus.flush        = do_redirect;
    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4;
    assign bus.fault        = fault_q;
    assign bus.halted       = halted_q;
    assign bus.stall_cycles = stall_cnt_q;

endmodule
